// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V pipeline front end.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- shown on the output whenever nothing valid is held.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO that decouples instruction fetch from decode stalls.
module fetch_fifo
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t slots [2];
  logic         wr_ptr;
  logic         rd_ptr;

  // Payload storage: written on push only.
  // NOTE: the slots are deliberately not reset; count alone says which ones hold data.
  always_ff @(posedge clk) begin
    if (push) begin
      slots[wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy bookkeeping; clear discards everything, including a same-cycle push.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program counter, synchronous instruction ROM, epoch-tagged
// in-flight tracking and a small output buffer feeding decode.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);

  // Preloaded from outside (hierarchically); there is no write port.
  logic [XLEN-1:0] instr_mem [0:IMEM_DEPTH-1];

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic [XLEN-1:0] mem_rdata;
  logic            inflight;
  logic            inflight_epoch;
  logic            epoch;

  logic [IDX_W-1:0] mem_index;
  logic [2:0]       occupancy;
  logic [1:0]       fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             issue;
  logic             push;
  logic             pop;

  // Out-of-range PCs wrap modulo the memory depth by taking only the index bits.
  assign mem_index = fetch_pc[IDX_W+1:2];

  // Handshake, issue and push decisions.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    out_valid  = (fifo_count != 2'd0);
    pop        = out_valid && out_ready && !redirect_valid;
    occupancy  = {1'b0, fifo_count} + {2'b00, inflight};
    // Issue only if the word can still land in the buffer after this cycle's pop.
    issue      = !redirect_valid && (occupancy <= 3'd1 + 3'(pop));
    // A response from before the last redirect carries a stale epoch and is dropped.
    push       = inflight && (inflight_epoch == epoch);
    push_entry = '{pc: inflight_pc, instr: mem_rdata};
  end

  // Output mux: present the head entry, or zero PC and a NOP when empty.
  always_comb begin
    out_pc    = '0;
    out_instr = NOP_INSTR;
    if (out_valid) begin
      out_pc    = fifo_head.pc;
      out_instr = fifo_head.instr;
    end
  end

  // Synchronous ROM read, paired with the PC it was read for.
  always_ff @(posedge clk) begin
    if (issue) begin
      mem_rdata   <= instr_mem[mem_index];
      inflight_pc <= fetch_pc;
    end
  end

  // PC, epoch and in-flight tracking; reset outranks redirect, redirect outranks issue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc       <= RESET_PC;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_epoch <= epoch;
        fetch_pc       <= fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~32'h0000_0003;
        epoch    <= ~epoch;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (redirect_valid),
    .count      (fifo_count),
    .head       (fifo_head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed per-cycle vector table
// followed by a randomized run against a stream-level reference model.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int DEPTH = 256;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  instr_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per cycle: check the outputs seen in that cycle, then drive its inputs.
  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        chk;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] gold [DEPTH];
  logic [31:0] prog [4];
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic chk, input logic ev, input logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.chk = chk; v.ev = ev;
    v.epc = ev ? epc : 32'h0;
    v.ei  = ev ? gold[epc[9:2]] : NOP_INSTR;
    vecs.push_back(v);
  endtask

  task automatic rst_row();
    add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic row(input logic rdy, input logic ev, input logic [31:0] epc);
    add(1'b1, rdy, 1'b0, 32'h0, 1'b1, ev, epc);
  endtask

  task automatic redir(input logic [31:0] rpc, input logic ev, input logic [31:0] epc);
    add(1'b1, 1'b1, 1'b1, rpc, 1'b1, ev, epc);
  endtask

  // Reference model state for the random phase: the address decode must see next.
  logic [31:0] exp_pc;
  int          gap;
  logic        showing;

  initial begin
    vec_t v;
    logic rdy, rv;
    logic [31:0] rpc;

    checks = 0;
    errors = 0;
    reset = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0020_8463;
    for (int i = 0; i < DEPTH; i++) begin
      gold[i] = (i < 4) ? prog[i] : $urandom;
      dut.instr_mem[i] = gold[i];
    end

    // Straight-line stream, decode always ready.
    rst_row();
    row(1, 0, 0); row(1, 0, 0);
    row(1, 1, 32'h0); row(1, 1, 32'h4); row(1, 1, 32'h8); row(1, 1, 32'hC); row(1, 1, 32'h10);

    // Redirect to an unaligned target while PC 8 is offered: PC 8 must not be consumed.
    rst_row();
    row(1, 0, 0); row(1, 0, 0); row(1, 1, 32'h0); row(1, 1, 32'h4);
    redir(32'h0000_0021, 1, 32'h8);
    row(1, 0, 0); row(1, 0, 0);
    row(1, 1, 32'h20); row(1, 1, 32'h24);

    // Decode stall in cycles 3..6: PC 4 held, then 8, C, 10 back to back.
    rst_row();
    row(1, 0, 0); row(1, 0, 0); row(1, 1, 32'h0);
    row(0, 1, 32'h4); row(0, 1, 32'h4); row(0, 1, 32'h4); row(0, 1, 32'h4);
    row(1, 1, 32'h4); row(1, 1, 32'h8); row(1, 1, 32'hC); row(1, 1, 32'h10);

    // Reset (with a competing redirect) while the buffer is full, then restart latency.
    rst_row();
    row(0, 0, 0); row(0, 0, 0); row(0, 1, 32'h0); row(0, 1, 32'h0);
    add(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h0);
    row(1, 0, 0); row(1, 0, 0); row(1, 1, 32'h0); row(1, 1, 32'h4);

    // Back-to-back redirects: only the second target may appear.
    rst_row();
    row(1, 0, 0); row(1, 0, 0); row(1, 1, 32'h0);
    redir(32'h40, 1, 32'h4);
    redir(32'h80, 0, 32'h0);
    row(1, 0, 0); row(1, 0, 0);
    row(1, 1, 32'h80); row(1, 1, 32'h84);

    // Index wrap: 0x3FC reads word 255, 0x400 reads word 0.
    rst_row();
    row(1, 0, 0); row(1, 0, 0);
    redir(32'h3FC, 1, 32'h0);
    row(1, 0, 0); row(1, 0, 0);
    row(1, 1, 32'h3FC); row(1, 1, 32'h400); row(1, 1, 32'h404);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.chk) begin
        check($sformatf("row%0d_valid", i), {31'b0, out_valid}, {31'b0, v.ev});
        check($sformatf("row%0d_pc", i), out_pc, v.epc);
        check($sformatf("row%0d_instr", i), out_instr, v.ei);
      end
      reset = v.rst;
      out_ready = v.rdy;
      redirect_valid = v.rv;
      redirect_pc = v.rpc;
      @(negedge clk);
    end

    // Randomized phase: the model only knows which address decode must see next.
    reset = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_pc = 32'h0;
    gap = 0;
    showing = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (out_valid) begin
        gap = 0;
        check($sformatf("rnd%0d_pc", c), out_pc, exp_pc);
        check($sformatf("rnd%0d_instr", c), out_instr, gold[exp_pc[9:2]]);
      end else begin
        gap++;
        if (showing) check($sformatf("rnd%0d_held_valid", c), {31'b0, out_valid}, 32'd1);
        check($sformatf("rnd%0d_idle_pc", c), out_pc, 32'h0);
        check($sformatf("rnd%0d_idle_instr", c), out_instr, NOP_INSTR);
        check($sformatf("rnd%0d_bubble_len", c), (gap > 2) ? 32'd1 : 32'd0, 32'd0);
      end

      rdy = ($urandom_range(0, 99) < 70);
      rv  = ($urandom_range(0, 99) < 6);
      rpc = $urandom_range(0, 1) ? ($urandom & 32'h0000_07FF) : $urandom;
      out_ready = rdy;
      redirect_valid = rv;
      redirect_pc = rpc;

      if (rv) begin
        exp_pc = {rpc[31:2], 2'b00};
        gap = 0;
        showing = 1'b0;
      end else if (out_valid && rdy) begin
        exp_pc = exp_pc + 32'd4;
        showing = 1'b0;
      end else begin
        showing = out_valid;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
